// File: rtl/util_pkg.sv
// rtl/util_pkg.sv - shared clock constant and period meter state type
package util_pkg;

   localparam int CLK_HZ = 100_000_000;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } meter_state_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-FF synchronizer with single-cycle rising-edge pulse
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic iAsync,
   output logic oRise
);

   logic [1:0] s;
   logic       s_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s      <= 2'b00;
         s_prev <= 1'b0;
      end else begin
         s      <= {s[0], iAsync};
         s_prev <= s[1];
      end
   end

   assign oRise = s[1] & ~s_prev;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - clk-cycle period meter with timeout on missing edges
// Optional min/max period tracking enabled by PERIOD_METER_MINMAX_EN.
module period_meter
   import util_pkg::*;
#(
   parameter int  P_MIN_FREQ_HZ = 25,
   localparam int P_MAX_CNT     = CLK_HZ / P_MIN_FREQ_HZ,
   localparam int CW            = $clog2(P_MAX_CNT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iSig,
   input  logic          iClr,
   output logic [CW-1:0] oPeriod,
   output logic          oValid,
   output logic          oTimeout,
   output logic          oBusy,
   output logic [CW-1:0] oMinPeriod,
   output logic [CW-1:0] oMaxPeriod
);

   localparam logic [CW-1:0] LAST = CW'(P_MAX_CNT - 1);

   meter_state_t  state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [CW-1:0] period_nx;
   logic          rise, load, tmo;

   edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .iAsync (iSig),
      .oRise  (rise)
   );

   assign period_nx = cnt + CW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (iClr) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (rise) state_nx = MEASURE;
            MEASURE: if (!rise && cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // An edge landing on the last count wins over the timeout.
   always_comb begin
      load   = 1'b0;
      tmo    = 1'b0;
      cnt_nx = cnt;
      if (iClr) begin
         cnt_nx = '0;
      end else begin
         case (state)
            IDLE: cnt_nx = '0;
            MEASURE: begin
               if (rise) begin
                  load   = 1'b1;
                  cnt_nx = '0;
               end else if (cnt == LAST) begin
                  tmo    = 1'b1;
                  cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            default: cnt_nx = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         oPeriod  <= '0;
         oValid   <= 1'b0;
         oTimeout <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         oValid   <= load;
         oTimeout <= tmo;
         if (iClr)      oPeriod <= '0;
         else if (load) oPeriod <= period_nx;
      end
   end

   assign oBusy = (state == MEASURE);

`ifdef PERIOD_METER_MINMAX_EN
   logic [CW-1:0] min_r, max_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_r <= '1;
         max_r <= '0;
      end else if (iClr) begin
         min_r <= '1;
         max_r <= '0;
      end else if (load) begin
         if (period_nx < min_r) min_r <= period_nx;
         if (period_nx > max_r) max_r <= period_nx;
      end
   end

   // Periods are never zero, so a zero max means nothing measured yet.
   assign oMinPeriod = (max_r == '0) ? '0 : min_r;
   assign oMaxPeriod = max_r;
`else
   assign oMinPeriod = '0;
   assign oMaxPeriod = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;

`ifdef PERIOD_METER_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sig_a = 1'b0, clr_a = 1'b0;
   logic        sig_b = 1'b0, clr_b = 1'b0;
   logic [21:0] per_a, min_a, max_a;
   logic [3:0]  per_b, min_b, max_b;
   logic        valid_a, tmo_a, busy_a;
   logic        valid_b, tmo_b, busy_b;

   int checks   = 0;
   int failures = 0;
   int cyc = 0, va_n = 0, ta_n = 0, vb_n = 0, tb_n = 0, va_last = 0, va_gap = 0;
   int snap_v, snap_t;

   always #5 clk = ~clk;

   period_meter dut_a (
      .clk(clk), .rst(rst), .iSig(sig_a), .iClr(clr_a),
      .oPeriod(per_a), .oValid(valid_a), .oTimeout(tmo_a), .oBusy(busy_a),
      .oMinPeriod(min_a), .oMaxPeriod(max_a)
   );

   period_meter #(.P_MIN_FREQ_HZ(10_000_000)) dut_b (
      .clk(clk), .rst(rst), .iSig(sig_b), .iClr(clr_b),
      .oPeriod(per_b), .oValid(valid_b), .oTimeout(tmo_b), .oBusy(busy_b),
      .oMinPeriod(min_b), .oMaxPeriod(max_b)
   );

   always @(negedge clk) begin
      cyc++;
      if (valid_a) begin
         if (va_last != 0) va_gap = cyc - va_last;
         va_last = cyc;
         va_n++;
      end
      if (tmo_a)   ta_n++;
      if (valid_b) vb_n++;
      if (tmo_b)   tb_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_per_a", 32'(per_a), 0);
      chk("rst_busy_a", 32'(busy_a), 0);
      chk("rst_valid_b", 32'(valid_b), 0);
      chk("rst_min_a", 32'(min_a), 0);
      rst = 1'b1;
      repeat (2) tick();

      // T1: 20-cycle square wave
      snap_v = va_n; snap_t = ta_n;
      for (int i = 0; i < 200; i++) begin
         sig_a = (i % 20) < 10;
         tick();
      end
      chk("t1_valid_count", 32'(va_n - snap_v), 9);
      chk("t1_period", 32'(per_a), 20);
      chk("t1_gap", 32'(va_gap), 20);
      chk("t1_timeouts", 32'(ta_n - snap_t), 0);
      chk("t1_busy", 32'(busy_a), 1);

      // T5: asynchronous reset mid-measurement
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t5_per_a", 32'(per_a), 0);
      chk("t5_busy_a", 32'(busy_a), 0);
      chk("t5_valid_a", 32'(valid_a), 0);
      chk("t5_tmo_a", 32'(tmo_a), 0);
      chk("t5_max_a", 32'(max_a), 0);
      tick();
      rst = 1'b1;
      repeat (2) tick();
      snap_v = va_n;
      for (int i = 0; i < 200; i++) begin
         sig_a = (i % 20) < 10;
         tick();
      end
      chk("t5_recover_count", 32'(va_n - snap_v), 9);
      chk("t5_recover_period", 32'(per_a), 20);

      // T4: clear 8 cycles into a measurement, then re-arm
      for (int i = 200; i < 260; i++) begin
         sig_a = (i % 20) < 10;
         clr_a = (i == 210);
         tick();
         if (i == 209) chk("t4_before_clr", 32'(per_a), 20);
         if (i == 210) begin
            chk("t4_clr_period", 32'(per_a), 0);
            chk("t4_clr_busy", 32'(busy_a), 0);
            snap_v = va_n;
         end
         if (i == 239) chk("t4_rearm_no_valid", 32'(va_n - snap_v), 0);
      end
      clr_a = 1'b0;
      chk("t4_after_count", 32'(va_n - snap_v), 1);
      chk("t4_after_period", 32'(per_a), 20);

      // T2: single edge then held high, P_MAX_CNT = 10
      snap_v = vb_n; snap_t = tb_n;
      sig_b = 1'b1;
      repeat (12) tick();
      chk("t2_busy_before", 32'(busy_b), 1);
      chk("t2_tmo_before", 32'(tmo_b), 0);
      tick();
      chk("t2_tmo_pulse", 32'(tmo_b), 1);
      chk("t2_busy_after", 32'(busy_b), 0);
      tick();
      chk("t2_tmo_one_cycle", 32'(tmo_b), 0);
      repeat (20) tick();
      chk("t2_tmo_count", 32'(tb_n - snap_t), 1);
      chk("t2_no_valid", 32'(vb_n - snap_v), 0);

      // T3: edges exactly P_MAX_CNT apart, edge wins over timeout
      clr_b = 1'b1; sig_b = 1'b0;
      tick();
      clr_b = 1'b0;
      snap_v = vb_n; snap_t = tb_n;
      for (int i = 0; i < 60; i++) begin
         sig_b = (i % 10) < 5;
         tick();
      end
      chk("t3_valid_count", 32'(vb_n - snap_v), 5);
      chk("t3_period", 32'(per_b), 10);
      chk("t3_no_timeout", 32'(tb_n - snap_t), 0);
      repeat (5) tick();
      chk("t3_late_timeout", 32'(tb_n - snap_t), 1);

      // T6: periods 30, 12, 50 then clear
      clr_a = 1'b1; sig_a = 1'b0;
      tick();
      clr_a = 1'b0;
      chk("t6_clr_min", 32'(min_a), 0);
      chk("t6_clr_max", 32'(max_a), 0);
      snap_v = va_n;
      for (int i = 0; i < 100; i++) begin
         sig_a = (i < 5) || (i >= 30 && i < 35) || (i >= 42 && i < 47) || (i >= 92 && i < 97);
         tick();
         if (i == 10) chk("t6_min_before_valid", 32'(min_a), 0);
         if (i == 40) chk("t6_min_first", 32'(min_a), MINMAX ? 30 : 0);
      end
      chk("t6_valid_count", 32'(va_n - snap_v), 3);
      chk("t6_period", 32'(per_a), 50);
      chk("t6_min", 32'(min_a), MINMAX ? 12 : 0);
      chk("t6_max", 32'(max_a), MINMAX ? 50 : 0);
      chk("t6_b_min", 32'(min_b), 0);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("t6_final_min", 32'(min_a), 0);
      chk("t6_final_max", 32'(max_a), 0);
      chk("t6_final_period", 32'(per_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
